// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared SPU condition-code definitions and the predicate evaluator.
package elixirchip_es1_spu_pkg;

    typedef enum logic [3:0] {
        COND_EQ     = 4'd0,
        COND_NE     = 4'd1,
        COND_LTU    = 4'd2,
        COND_GEU    = 4'd3,
        COND_LT     = 4'd4,
        COND_GE     = 4'd5,
        COND_LE     = 4'd6,
        COND_GT     = 4'd7,
        COND_LEU    = 4'd8,
        COND_GTU    = 4'd9,
        COND_ALWAYS = 4'd10,
        COND_NEVER  = 4'd11
    } cond_t;

    // Codes 12..15 are reserved and evaluate false.
    function automatic logic spu_cond_eval(input cond_t cond, input logic z, input logic n,
                                           input logic c, input logic v);
        logic lt;
        logic res;
        lt  = n ^ v;
        res = 1'b0;
        case (cond)
            COND_EQ:     res = z;
            COND_NE:     res = ~z;
            COND_LTU:    res = ~c;
            COND_GEU:    res = c;
            COND_LT:     res = lt;
            COND_GE:     res = ~lt;
            COND_LE:     res = z | lt;
            COND_GT:     res = ~z & ~lt;
            COND_LEU:    res = ~c | z;
            COND_GTU:    res = c & ~z;
            COND_ALWAYS: res = 1'b1;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_delay.sv
// Clock-enable gated single-bit delay line; DEPTH=0 is a straight wire.
module elixirchip_es1_spu_delay #(
    parameter int   DEPTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic reset,
    input  logic clk,
    input  logic cke,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_sr
            logic [DEPTH-1:0] sr_q;

            // Shift one position per enabled edge; reset wins over cke.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr_q <= {DEPTH{RESET_VAL}};
                end else if (cke) begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/elixirchip_es1_spu_op_cond.sv
// Condition evaluator downstream of op_sub: derives Z/N/C/V from the
// subtraction result, evaluates a condition code, and delivers the predicate
// through a LATENCY-deep pipeline.
// Build option: ELIXIRCHIP_ES1_SPU_OP_COND_CHAIN_EN enables the zero-flag
// accumulator used for multi-word compares; without it s_chain is ignored.
module elixirchip_es1_spu_op_cond
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter logic  CLEAR_FLAG = 1'b0,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic  reset,
    input  logic  clk,
    input  logic  cke,
    input  cond_t s_cond,
    input  logic  s_chain,
    input  data_t s_data,
    input  logic  s_msb_c,
    input  logic  s_carry,
    input  logic  s_clear,
    input  logic  s_valid,
    output logic  m_flag
);

    logic flag_z, flag_n, flag_c, flag_v;
    logic zeff;
    logic pred;

    assign flag_z = (s_data == '0);
    assign flag_n = s_data[DATA_BITS-1];
    assign flag_c = s_carry;
    assign flag_v = s_carry ^ s_msb_c;

`ifdef ELIXIRCHIP_ES1_SPU_OP_COND_CHAIN_EN
    // z_acc holds "all lower words so far were zero"; it idles at 1 so a
    // chained word with no predecessor behaves as unchained.
    logic z_acc_q, z_acc_d;

    assign zeff = s_chain ? (z_acc_q & flag_z) : flag_z;

    // Next accumulator: clear re-arms the chain, accepted words update it.
    always_comb begin
        z_acc_d = z_acc_q;
        if (cke) begin
            if (s_clear)      z_acc_d = 1'b1;
            else if (s_valid) z_acc_d = zeff;
        end
    end

    // Accumulator register; reset abandons any chain in progress.
    always_ff @(posedge clk) begin
        if (reset) z_acc_q <= 1'b1;
        else       z_acc_q <= z_acc_d;
    end
`else
    assign zeff = flag_z;
`endif

    assign pred = spu_cond_eval(s_cond, zeff, flag_n, flag_c, flag_v);

    generate
        if (LATENCY == 0) begin : g_comb
            assign m_flag = s_clear ? CLEAR_FLAG : pred;
        end else begin : g_pipe
            logic st1_q, st1_d;

            // Stage 1 next value: clear beats valid, otherwise hold.
            always_comb begin
                st1_d = st1_q;
                if (cke) begin
                    if (s_clear)      st1_d = CLEAR_FLAG;
                    else if (s_valid) st1_d = pred;
                end
            end

            // Stage 1 register.
            always_ff @(posedge clk) begin
                if (reset) st1_q <= CLEAR_FLAG;
                else       st1_q <= st1_d;
            end

            elixirchip_es1_spu_delay #(
                .DEPTH     (LATENCY - 1),
                .RESET_VAL (CLEAR_FLAG)
            ) u_delay (
                .reset (reset),
                .clk   (clk),
                .cke   (cke),
                .d_i   (st1_q),
                .q_o   (m_flag)
            );
        end
    endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_cond.sv
// Directed bench for elixirchip_es1_spu_op_cond at LATENCY=2, DATA_BITS=8.
// Chained expectations follow ELIXIRCHIP_ES1_SPU_OP_COND_CHAIN_EN.
module tb_elixirchip_es1_spu_op_cond;
    import elixirchip_es1_spu_pkg::*;

`ifdef ELIXIRCHIP_ES1_SPU_OP_COND_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic       reset, clk, cke;
    cond_t      s_cond;
    logic       s_chain;
    logic [7:0] s_data;
    logic       s_msb_c, s_carry, s_clear, s_valid;
    logic       m_flag;

    int n_chk  = 0;
    int n_fail = 0;

    elixirchip_es1_spu_op_cond #(
        .LATENCY    (2),
        .DATA_BITS  (8),
        .CLEAR_FLAG (1'b0)
    ) dut (
        .reset   (reset),
        .clk     (clk),
        .cke     (cke),
        .s_cond  (s_cond),
        .s_chain (s_chain),
        .s_data  (s_data),
        .s_msb_c (s_msb_c),
        .s_carry (s_carry),
        .s_clear (s_clear),
        .s_valid (s_valid),
        .m_flag  (m_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input cond_t c, input logic ch, input logic [7:0] d, input logic mc,
                         input logic cy, input logic v, input logic clr);
        s_cond  = c;
        s_chain = ch;
        s_data  = d;
        s_msb_c = mc;
        s_carry = cy;
        s_valid = v;
        s_clear = clr;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cke   = 1'b1;
        drive(COND_ALWAYS, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            n_chk++;
            if (m_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d] m_flag=%b required=0", k, m_flag);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk++;
            if (m_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release[%0d] m_flag=%b required=0", k, m_flag);
            end
        end
    endtask

    // 127 - (-128): N=1 V=1 C=0 Z=0
    task automatic test_signed_unsigned();
        cond_t cs[4] = '{COND_GE, COND_LTU, COND_LT, COND_GEU};
        logic  ex[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) drive(cs[k], 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
            else       drive(COND_NEVER, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (k >= 1) begin
                n_chk++;
                if (m_flag !== ex[k-1]) begin
                    n_fail++;
                    $display("FAIL signed[%0d] m_flag=%b required=%b", k-1, m_flag, ex[k-1]);
                end
            end
        end
    endtask

    // -128 - 127: N=0 V=1 C=1 Z=0
    task automatic test_overflow();
        cond_t cs[6] = '{COND_LT, COND_GTU, COND_LE, COND_GE, COND_NE, COND_EQ};
        logic  ex[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) drive(cs[k], 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
            else       drive(COND_NEVER, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (k >= 1) begin
                n_chk++;
                if (m_flag !== ex[k-1]) begin
                    n_fail++;
                    $display("FAIL overflow[%0d] m_flag=%b required=%b", k-1, m_flag, ex[k-1]);
                end
            end
        end
    endtask

    // Zero data with carry set: Z=1 C=1 N=0 V=0; includes reserved codes.
    task automatic test_cond_misc();
        cond_t cs[6] = '{cond_t'(4'd12), COND_ALWAYS, COND_NEVER, cond_t'(4'd15), COND_LEU, COND_GT};
        logic  ex[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k <= 6; k++) begin
            if (k < 6) drive(cs[k], 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
            else       drive(COND_NEVER, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (k >= 1) begin
                n_chk++;
                if (m_flag !== ex[k-1]) begin
                    n_fail++;
                    $display("FAIL cond_misc[%0d] m_flag=%b required=%b", k-1, m_flag, ex[k-1]);
                end
            end
        end
    endtask

    task automatic test_chain();
        logic [7:0] ds[4] = '{8'h00, 8'h00, 8'h05, 8'h00};
        logic       ch[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       ex[4] = '{1'b1, 1'b1, 1'b0, ~CHAIN};
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) drive(COND_EQ, ch[k], ds[k], 1'b1, 1'b1, 1'b1, 1'b0);
            else       drive(COND_NEVER, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (k >= 1) begin
                n_chk++;
                if (m_flag !== ex[k-1]) begin
                    n_fail++;
                    $display("FAIL chain[%0d] m_flag=%b required=%b", k-1, m_flag, ex[k-1]);
                end
            end
        end
    endtask

    task automatic test_cke_valid_hold();
        drive(COND_EQ, 1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);   // result 0
        tick();
        drive(COND_EQ, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);   // result 1
        tick();
        n_chk++;
        if (m_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_pre m_flag=%b required=0", m_flag);
        end
        cke = 1'b0;
        drive(COND_EQ, 1'b0, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk++;
            if (m_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cke0[%0d] m_flag=%b required=0", k, m_flag);
            end
        end
        cke = 1'b1;
        drive(COND_EQ, 1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++;
            if (m_flag !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_invalid[%0d] m_flag=%b required=1", k, m_flag);
            end
        end
    endtask

    task automatic test_clear();
        drive(COND_NE, 1'b0, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0);   // result 1, z_acc -> 0
        tick();
        drive(COND_ALWAYS, 1'b0, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        n_chk++;
        if (m_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_pre m_flag=%b required=1", m_flag);
        end
        drive(COND_EQ, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);   // chained after clear
        tick();
        n_chk++;
        if (m_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flag m_flag=%b required=0", m_flag);
        end
        drive(COND_NEVER, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_chk++;
        if (m_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_chain m_flag=%b required=1", m_flag);
        end
    endtask

    // Reset between chained words drops the accumulated "non-zero".
    task automatic test_reset_mid_chain();
        drive(COND_EQ, 1'b0, 8'h05, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        reset = 1'b1;
        drive(COND_NEVER, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(COND_EQ, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(COND_NEVER, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_chk++;
        if (m_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_chain m_flag=%b required=1", m_flag);
        end
    endtask

    initial begin
        test_reset();
        test_signed_unsigned();
        test_overflow();
        test_cond_misc();
        test_chain();
        test_cke_valid_hold();
        test_clear();
        test_reset_mid_chain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
